// File: rtl/decode_ctrl_pkg.sv
// decode_ctrl_pkg: MIPS opcode / funct / REGIMM-rt constants, memory-size and
// mul/div encodings, and the registered ID/EX control word.
package decode_ctrl_pkg;
   localparam logic [5:0] EXE_SPECIAL = 6'h00;
   localparam logic [5:0] EXE_REGIMM  = 6'h01;
   localparam logic [5:0] EXE_J       = 6'h02;
   localparam logic [5:0] EXE_JAL     = 6'h03;
   localparam logic [5:0] EXE_BEQ     = 6'h04;
   localparam logic [5:0] EXE_BNE     = 6'h05;
   localparam logic [5:0] EXE_BLEZ    = 6'h06;
   localparam logic [5:0] EXE_BGTZ    = 6'h07;
   localparam logic [5:0] EXE_ADDI    = 6'h08;
   localparam logic [5:0] EXE_ADDIU   = 6'h09;
   localparam logic [5:0] EXE_SLTI    = 6'h0A;
   localparam logic [5:0] EXE_SLTIU   = 6'h0B;
   localparam logic [5:0] EXE_ANDI    = 6'h0C;
   localparam logic [5:0] EXE_ORI     = 6'h0D;
   localparam logic [5:0] EXE_XORI    = 6'h0E;
   localparam logic [5:0] EXE_LUI     = 6'h0F;
   localparam logic [5:0] EXE_LB      = 6'h20;
   localparam logic [5:0] EXE_LH      = 6'h21;
   localparam logic [5:0] EXE_LW      = 6'h23;
   localparam logic [5:0] EXE_LBU     = 6'h24;
   localparam logic [5:0] EXE_LHU     = 6'h25;
   localparam logic [5:0] EXE_SB      = 6'h28;
   localparam logic [5:0] EXE_SH      = 6'h29;
   localparam logic [5:0] EXE_SW      = 6'h2B;
   localparam logic [5:0] EXE_OP3F    = 6'h3F;

   localparam logic [5:0] EXE_SLL   = 6'h00;
   localparam logic [5:0] EXE_SRL   = 6'h02;
   localparam logic [5:0] EXE_SRA   = 6'h03;
   localparam logic [5:0] EXE_SLLV  = 6'h04;
   localparam logic [5:0] EXE_SRLV  = 6'h06;
   localparam logic [5:0] EXE_SRAV  = 6'h07;
   localparam logic [5:0] EXE_JR    = 6'h08;
   localparam logic [5:0] EXE_JALR  = 6'h09;
   localparam logic [5:0] EXE_MFHI  = 6'h10;
   localparam logic [5:0] EXE_MTHI  = 6'h11;
   localparam logic [5:0] EXE_MFLO  = 6'h12;
   localparam logic [5:0] EXE_MTLO  = 6'h13;
   localparam logic [5:0] EXE_MULT  = 6'h18;
   localparam logic [5:0] EXE_MULTU = 6'h19;
   localparam logic [5:0] EXE_DIV   = 6'h1A;
   localparam logic [5:0] EXE_DIVU  = 6'h1B;
   localparam logic [5:0] EXE_ADD   = 6'h20;
   localparam logic [5:0] EXE_ADDU  = 6'h21;
   localparam logic [5:0] EXE_SUB   = 6'h22;
   localparam logic [5:0] EXE_SUBU  = 6'h23;
   localparam logic [5:0] EXE_AND   = 6'h24;
   localparam logic [5:0] EXE_OR    = 6'h25;
   localparam logic [5:0] EXE_XOR   = 6'h26;
   localparam logic [5:0] EXE_NOR   = 6'h27;
   localparam logic [5:0] EXE_SLT   = 6'h2A;
   localparam logic [5:0] EXE_SLTU  = 6'h2B;

   localparam logic [4:0] EXE_BLTZ   = 5'h00;
   localparam logic [4:0] EXE_BGEZ   = 5'h01;
   localparam logic [4:0] EXE_BLTZAL = 5'h10;
   localparam logic [4:0] EXE_BGEZAL = 5'h11;

   localparam logic [1:0] MEM_BYTE = 2'd0;
   localparam logic [1:0] MEM_HALF = 2'd1;
   localparam logic [1:0] MEM_WORD = 2'd2;

   localparam logic [1:0] MD_MULT  = 2'd0;
   localparam logic [1:0] MD_MULTU = 2'd1;
   localparam logic [1:0] MD_DIV   = 2'd2;
   localparam logic [1:0] MD_DIVU  = 2'd3;

   typedef struct packed {
      logic       regwrite;
      logic       regdst;
      logic       alusrc;
      logic       branch;
      logic       memwrite;
      logic       memtoreg;
      logic       jump;
      logic       al;
      logic       jumpr;
      logic [1:0] mem_size;
      logic       mem_signed;
      logic [1:0] muldiv_op;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
endpackage

// File: rtl/decode_ctrl_comb.sv
// decode_comb: purely combinational main decoder, instruction -> control word,
// HI/LO-class flag, mul/div flag and reserved-instruction flag.
module decode_comb
   import decode_ctrl_pkg::*;
(
   input  logic [31:0]       i_instr,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic              o_muldiv,
   output logic              o_hilo,
   output logic              o_ri
);
   logic [5:0] w_op;
   logic [5:0] w_funct;
   logic [4:0] w_rt;
   logic       w_unused;
   ctrl_t      w_c;

   assign w_op     = i_instr[31:26];
   assign w_rt     = i_instr[20:16];
   assign w_funct  = i_instr[5:0];
   assign w_unused = ^{i_instr[25:21], i_instr[15:6]};

   always_comb begin
      w_c      = '0;
      o_muldiv = 1'b0;
      o_hilo   = 1'b0;
      o_ri     = 1'b0;
      case (w_op)
         EXE_SPECIAL: begin
            case (w_funct)
               EXE_SLL, EXE_SRL, EXE_SRA, EXE_SLLV, EXE_SRLV, EXE_SRAV,
               EXE_ADD, EXE_ADDU, EXE_SUB, EXE_SUBU, EXE_AND, EXE_OR,
               EXE_XOR, EXE_NOR, EXE_SLT, EXE_SLTU: begin
                  w_c.regwrite = 1'b1;
                  w_c.regdst   = 1'b1;
               end
               EXE_MFHI, EXE_MFLO: begin
                  w_c.regwrite = 1'b1;
                  w_c.regdst   = 1'b1;
                  o_hilo       = 1'b1;
               end
               EXE_MTHI, EXE_MTLO: o_hilo = 1'b1;
               EXE_MULT, EXE_MULTU, EXE_DIV, EXE_DIVU: begin
                  o_hilo        = 1'b1;
                  o_muldiv      = 1'b1;
                  // funct 0x18..0x1B low bits line up with the MD_* encoding
                  w_c.muldiv_op = w_funct[1:0];
               end
               EXE_JR: begin
                  w_c.jump  = 1'b1;
                  w_c.jumpr = 1'b1;
               end
               EXE_JALR: begin
                  w_c.regwrite = 1'b1;
                  w_c.regdst   = 1'b1;
                  w_c.jump     = 1'b1;
                  w_c.jumpr    = 1'b1;
                  w_c.al       = 1'b1;
               end
               default: o_ri = 1'b1;
            endcase
         end
         EXE_REGIMM: begin
            case (w_rt)
               EXE_BLTZ, EXE_BGEZ: w_c.branch = 1'b1;
               EXE_BLTZAL, EXE_BGEZAL: begin
                  w_c.branch   = 1'b1;
                  w_c.regwrite = 1'b1;
                  w_c.al       = 1'b1;
               end
               default: o_ri = 1'b1;
            endcase
         end
         EXE_J: w_c.jump = 1'b1;
         EXE_JAL: begin
            w_c.jump     = 1'b1;
            w_c.regwrite = 1'b1;
            w_c.al       = 1'b1;
         end
         EXE_BEQ, EXE_BNE, EXE_BGTZ, EXE_BLEZ: w_c.branch = 1'b1;
         EXE_ANDI, EXE_ORI, EXE_XORI, EXE_LUI, EXE_ADDI, EXE_ADDIU,
         EXE_SLTI, EXE_SLTIU: begin
            w_c.regwrite = 1'b1;
            w_c.alusrc   = 1'b1;
         end
         EXE_LB, EXE_LBU, EXE_LH, EXE_LHU, EXE_LW: begin
            w_c.regwrite   = 1'b1;
            w_c.alusrc     = 1'b1;
            w_c.memtoreg   = 1'b1;
            w_c.mem_size   = (w_op == EXE_LW) ? MEM_WORD :
                             (w_op == EXE_LH || w_op == EXE_LHU) ? MEM_HALF : MEM_BYTE;
            w_c.mem_signed = (w_op == EXE_LB) || (w_op == EXE_LH);
         end
         EXE_SB, EXE_SH, EXE_SW: begin
            w_c.alusrc   = 1'b1;
            w_c.memwrite = 1'b1;
            w_c.mem_size = (w_op == EXE_SW) ? MEM_WORD :
                           (w_op == EXE_SH) ? MEM_HALF : MEM_BYTE;
         end
         EXE_OP3F: begin
            w_c.regwrite = 1'b1;
            w_c.regdst   = 1'b1;
         end
         default: o_ri = 1'b1;
      endcase
   end

   assign o_ctrl = w_c;
endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: ID/EX control register with stall/flush plus MULT/DIV HI/LO
// occupancy FSM. Define DECODE_RI_EXC_EN to register the reserved-instruction flag.
module decode_ctrl
   import decode_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 2,
   parameter int DIV_CYCLES  = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        id_valid,
   input  logic [31:0] id_instr,
   input  logic        stall_in,
   input  logic        flush,
   output logic        id_ready,
   output logic        ex_valid,
   output logic        ex_regwrite,
   output logic        ex_regdst,
   output logic        ex_alusrc,
   output logic        ex_branch,
   output logic        ex_memwrite,
   output logic        ex_memtoreg,
   output logic        ex_jump,
   output logic        ex_al,
   output logic        ex_jumpr,
   output logic [1:0]  ex_mem_size,
   output logic        ex_mem_signed,
   output logic        ex_muldiv_start,
   output logic [1:0]  ex_muldiv_op,
   output logic        hilo_done,
   output logic        busy,
   output logic        ex_ri_exc
);
   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   logic [CTRL_W-1:0] w_ctrl_bits;
   ctrl_t             w_ctrl;
   logic              w_muldiv, w_hilo, w_ri;
   logic              w_busy, w_block, w_accept, w_launch;
   logic [CNT_W-1:0]  w_load;

   ctrl_t             r_ex;
   logic              r_ex_valid, r_start, r_hilo_done;
   state_e            r_state;
   logic [CNT_W-1:0]  r_cnt;

   decode_comb u_decode_comb (
      .i_instr  (id_instr),
      .o_ctrl   (w_ctrl_bits),
      .o_muldiv (w_muldiv),
      .o_hilo   (w_hilo),
      .o_ri     (w_ri)
   );

   assign w_ctrl = ctrl_t'(w_ctrl_bits);
   assign w_busy = (r_state == ST_BUSY);
   // Dependent HI/LO moves may go in the hilo_done cycle; a new mul/div may not.
   assign w_block  = w_busy & (w_muldiv | (w_hilo & ~r_hilo_done));
   assign w_accept = resetn & id_valid & ~stall_in & ~w_block;
   assign w_launch = w_accept & w_muldiv & ~flush;
   assign w_load   = w_ctrl.muldiv_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ex_valid <= 1'b0;
         r_ex       <= '0;
         r_start    <= 1'b0;
      end else begin
         r_start <= 1'b0;
         if (flush) begin
            r_ex_valid <= 1'b0;
            r_ex       <= '0;
         end else if (stall_in) begin
            r_ex_valid <= r_ex_valid;
         end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_ex       <= w_ctrl;
            r_start    <= w_muldiv;
         end else begin
            r_ex_valid <= 1'b0;
            r_ex       <= '0;
         end
      end
   end

   // Occupancy counter runs regardless of stall/flush once a mul/div is launched.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_hilo_done <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_hilo_done <= 1'b0;
               if (w_launch) begin
                  r_state     <= ST_BUSY;
                  r_cnt       <= w_load;
                  r_hilo_done <= (w_load == CNT_W'(1));
               end
            end
            ST_BUSY: begin
               if (r_cnt == CNT_W'(1)) begin
                  r_state     <= ST_IDLE;
                  r_cnt       <= '0;
                  r_hilo_done <= 1'b0;
               end else begin
                  r_cnt       <= r_cnt - CNT_W'(1);
                  r_hilo_done <= (r_cnt == CNT_W'(2));
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cnt       <= '0;
               r_hilo_done <= 1'b0;
            end
         endcase
      end
   end

`ifdef DECODE_RI_EXC_EN
   logic r_ri;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)        r_ri <= 1'b0;
      else if (flush)     r_ri <= 1'b0;
      else if (!stall_in) r_ri <= w_accept & w_ri;
   end
   assign ex_ri_exc = r_ri;
`else
   logic w_unused_ri;
   assign w_unused_ri = w_ri;
   assign ex_ri_exc   = 1'b0;
`endif

   assign id_ready        = w_accept;
   assign ex_valid        = r_ex_valid;
   assign ex_regwrite     = r_ex.regwrite;
   assign ex_regdst       = r_ex.regdst;
   assign ex_alusrc       = r_ex.alusrc;
   assign ex_branch       = r_ex.branch;
   assign ex_memwrite     = r_ex.memwrite;
   assign ex_memtoreg     = r_ex.memtoreg;
   assign ex_jump         = r_ex.jump;
   assign ex_al           = r_ex.al;
   assign ex_jumpr        = r_ex.jumpr;
   assign ex_mem_size     = r_ex.mem_size;
   assign ex_mem_signed   = r_ex.mem_signed;
   assign ex_muldiv_op    = r_ex.muldiv_op;
   assign ex_muldiv_start = r_start;
   assign hilo_done       = r_hilo_done;
   assign busy            = w_busy;
endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: cycle-level reference model with an expected-word queue for
// decode_ctrl; DECODE_RI_EXC_EN selects the expected reserved-instruction flag.
module tb_decode_ctrl;
   localparam int MULTC = 2;
   localparam int DIVC  = 32;

   typedef struct packed {
      logic       rw, rd, as, br, mw, mr, j, al, jr;
      logic [1:0] sz;
      logic       sg;
      logic [1:0] mop;
   } word_t;

   logic        clk, resetn, id_valid, stall_in, flush;
   logic [31:0] id_instr;
   logic        id_ready, ex_valid, ex_regwrite, ex_regdst, ex_alusrc, ex_branch;
   logic        ex_memwrite, ex_memtoreg, ex_jump, ex_al, ex_jumpr, ex_mem_signed;
   logic [1:0]  ex_mem_size, ex_muldiv_op;
   logic        ex_muldiv_start, hilo_done, busy, ex_ri_exc;

   int          n_vec, n_err, m_cnt, start_cnt;
   logic [16:0] m_ex;
   logic [16:0] exp_q[$];

   decode_ctrl #(.MULT_CYCLES(MULTC), .DIV_CYCLES(DIVC)) dut (
      .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_instr(id_instr),
      .stall_in(stall_in), .flush(flush), .id_ready(id_ready), .ex_valid(ex_valid),
      .ex_regwrite(ex_regwrite), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc),
      .ex_branch(ex_branch), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
      .ex_jump(ex_jump), .ex_al(ex_al), .ex_jumpr(ex_jumpr), .ex_mem_size(ex_mem_size),
      .ex_mem_signed(ex_mem_signed), .ex_muldiv_start(ex_muldiv_start),
      .ex_muldiv_op(ex_muldiv_op), .hilo_done(hilo_done), .busy(busy),
      .ex_ri_exc(ex_ri_exc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt,
                                      input logic [5:0] fn);
      logic [31:0] r;
      r        = $urandom;
      r[31:26] = op;
      r[20:16] = rt;
      r[5:0]   = fn;
      return r;
   endfunction

   // Reference decode built straight from the instruction table.
   function automatic void ref_dec(input logic [31:0] ins, output word_t w,
                                   output logic md, output logic hl, output logic ri);
      logic [5:0] op, fn;
      logic [4:0] rt;
      op = ins[31:26]; rt = ins[20:16]; fn = ins[5:0];
      w = '0; md = 1'b0; hl = 1'b0; ri = 1'b0;
      case (op)
         6'h00: case (fn)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin w.rw = 1; w.rd = 1; end
            6'h08: begin w.j = 1; w.jr = 1; end
            6'h09: begin w.rw = 1; w.rd = 1; w.j = 1; w.jr = 1; w.al = 1; end
            6'h10, 6'h12: begin w.rw = 1; w.rd = 1; hl = 1; end
            6'h11, 6'h13: hl = 1;
            6'h18: begin hl = 1; md = 1; w.mop = 2'd0; end
            6'h19: begin hl = 1; md = 1; w.mop = 2'd1; end
            6'h1A: begin hl = 1; md = 1; w.mop = 2'd2; end
            6'h1B: begin hl = 1; md = 1; w.mop = 2'd3; end
            default: ri = 1;
         endcase
         6'h01: case (rt)
            5'h00, 5'h01: w.br = 1;
            5'h10, 5'h11: begin w.br = 1; w.rw = 1; w.al = 1; end
            default: ri = 1;
         endcase
         6'h02: w.j = 1;
         6'h03: begin w.j = 1; w.rw = 1; w.al = 1; end
         6'h04, 6'h05, 6'h06, 6'h07: w.br = 1;
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin w.rw = 1; w.as = 1; end
         6'h20: begin w.rw = 1; w.as = 1; w.mr = 1; w.sz = 2'd0; w.sg = 1; end
         6'h21: begin w.rw = 1; w.as = 1; w.mr = 1; w.sz = 2'd1; w.sg = 1; end
         6'h23: begin w.rw = 1; w.as = 1; w.mr = 1; w.sz = 2'd2; end
         6'h24: begin w.rw = 1; w.as = 1; w.mr = 1; w.sz = 2'd0; end
         6'h25: begin w.rw = 1; w.as = 1; w.mr = 1; w.sz = 2'd1; end
         6'h28: begin w.as = 1; w.mw = 1; w.sz = 2'd0; end
         6'h29: begin w.as = 1; w.mw = 1; w.sz = 2'd1; end
         6'h2B: begin w.as = 1; w.mw = 1; w.sz = 2'd2; end
         6'h3F: begin w.rw = 1; w.rd = 1; end
         default: ri = 1;
      endcase
`ifndef DECODE_RI_EXC_EN
      ri = 1'b0;
`endif
   endfunction

   function automatic logic [31:0] pick(input int k);
      logic [4:0] r5;
      logic [5:0] r6;
      r5 = 5'($urandom);
      r6 = 6'($urandom);
      case (k)
         0: return mk(6'h00, r5, 6'h21);
         1: return mk(6'h00, r5, 6'h23);
         2: return mk(6'h00, r5, 6'h08);
         3: return mk(6'h00, r5, 6'h09);
         4: return mk(6'h00, r5, 6'h10);
         5: return mk(6'h00, r5, 6'h12);
         6: return mk(6'h00, r5, 6'h11);
         7: return mk(6'h00, r5, 6'h13);
         8: return mk(6'h00, r5, 6'h18);
         9: return mk(6'h00, r5, 6'h19);
         10: return mk(6'h00, r5, 6'h1A);
         11: return mk(6'h00, r5, 6'h1B);
         12: return mk(6'h00, r5, 6'h01);
         13: return mk(6'h01, 5'h00, r6);
         14: return mk(6'h01, 5'h11, r6);
         15: return mk(6'h01, 5'h05, r6);
         16: return mk(6'h02, r5, r6);
         17: return mk(6'h03, r5, r6);
         18: return mk(6'h05, r5, r6);
         19: return mk(6'h06, r5, r6);
         20: return mk(6'h0D, r5, r6);
         21: return mk(6'h0F, r5, r6);
         22: return mk(6'h0B, r5, r6);
         23: return mk(6'h20, r5, r6);
         24: return mk(6'h25, r5, r6);
         25: return mk(6'h21, r5, r6);
         26: return mk(6'h28, r5, r6);
         27: return mk(6'h29, r5, r6);
         28: return mk(6'h2B, r5, r6);
         29: return mk(6'h3F, r5, r6);
         30: return mk(6'h13, r5, r6);
         default: return mk(6'h23, r5, r6);
      endcase
   endfunction

   function automatic logic [16:0] obs();
      return {ex_valid, ex_regwrite, ex_regdst, ex_alusrc, ex_branch, ex_memwrite,
              ex_memtoreg, ex_jump, ex_al, ex_jumpr, ex_mem_size, ex_mem_signed,
              ex_muldiv_op, ex_muldiv_start, ex_ri_exc};
   endfunction

   // One clock: drive at negedge, check combinational outputs, predict EX, check after edge.
   task automatic step(input logic v, input logic [31:0] ins, input logic st,
                       input logic fl, output logic acc);
      word_t w;
      logic  md, hl, ri, rdy, bsy, hd;
      id_valid = v; id_instr = ins; stall_in = st; flush = fl;
      #1;
      ref_dec(ins, w, md, hl, ri);
      bsy = (m_cnt != 0);
      hd  = (m_cnt == 1);
      rdy = v & ~st & ~(bsy & (md | (hl & ~hd)));
      check_eq("id_ready", {31'd0, id_ready}, {31'd0, rdy});
      check_eq("busy", {31'd0, busy}, {31'd0, bsy});
      check_eq("hilo_done", {31'd0, hilo_done}, {31'd0, hd});
      if (fl)       m_ex = '0;
      else if (st)  m_ex[1] = 1'b0;
      else if (rdy) m_ex = {1'b1, w, md, ri};
      else          m_ex = '0;
      if (bsy)                m_cnt = m_cnt - 1;
      else if (rdy & md & ~fl) m_cnt = w.mop[1] ? DIVC : MULTC;
      exp_q.push_back(m_ex);
      acc = rdy;
      @(posedge clk);
      #1;
      if (ex_muldiv_start) start_cnt++;
      check_eq("ex_word", {15'd0, obs()}, {15'd0, exp_q.pop_front()});
      @(negedge clk);
   endtask

   task automatic reset_check(input string tag);
      check_eq({tag, "_id_ready"}, {31'd0, id_ready}, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_hilo_done"}, {31'd0, hilo_done}, 32'd0);
      check_eq({tag, "_ex_word"}, {15'd0, obs()}, 32'd0);
   endtask

   initial begin
      logic acc;
      int   n;
      n_vec = 0; n_err = 0; m_cnt = 0; m_ex = '0; start_cnt = 0;
      resetn = 1'b0; id_valid = 1'b1; id_instr = mk(6'h23, 5'd3, 6'h04);
      stall_in = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      reset_check("reset");
      resetn = 1'b1;
      step(1'b1, mk(6'h23, 5'd3, 6'h04), 1'b0, 1'b0, acc);
      step(1'b0, 32'd0, 1'b0, 1'b0, acc);

      // DIVU, independent ADDIU/BEQ, then MFLO waiting on HI/LO
      start_cnt = 0;
      step(1'b1, mk(6'h00, 5'd2, 6'h1B), 1'b0, 1'b0, acc);
      step(1'b1, mk(6'h09, 5'd4, 6'h3C), 1'b0, 1'b0, acc);
      step(1'b1, mk(6'h04, 5'd5, 6'h01), 1'b0, 1'b0, acc);
      n = 0; acc = 1'b0;
      while (!acc && n < 40) begin
         step(1'b1, mk(6'h00, 5'd0, 6'h12), 1'b0, 1'b0, acc);
         n++;
      end
      check_eq("mflo_wait_cycles", n, DIVC - 2);
      check_eq("divu_start_pulses", start_cnt, 1);

      // MULT then 3 stall cycles, then stall+flush on a held ADDU
      start_cnt = 0;
      step(1'b1, mk(6'h00, 5'd1, 6'h18), 1'b0, 1'b0, acc);
      repeat (3) step(1'b1, mk(6'h00, 5'd6, 6'h21), 1'b1, 1'b0, acc);
      check_eq("mult_start_pulses", start_cnt, 1);
      step(1'b1, mk(6'h00, 5'd6, 6'h21), 1'b0, 1'b0, acc);
      step(1'b1, mk(6'h00, 5'd7, 6'h21), 1'b1, 1'b0, acc);
      step(1'b1, mk(6'h00, 5'd7, 6'h21), 1'b1, 1'b1, acc);
      step(1'b1, mk(6'h00, 5'd0, 6'h10), 1'b0, 1'b0, acc);
      // MULTU squashed in its issue cycle must not launch
      step(1'b1, mk(6'h00, 5'd1, 6'h19), 1'b0, 1'b1, acc);
      repeat (2) step(1'b0, 32'd0, 1'b0, 1'b0, acc);

      // Reset on cycle 10 of a DIV
      step(1'b1, mk(6'h00, 5'd1, 6'h1A), 1'b0, 1'b0, acc);
      repeat (9) step(1'b0, 32'd0, 1'b0, 1'b0, acc);
      id_valid = 1'b1; id_instr = mk(6'h00, 5'd1, 6'h1A);
      resetn = 1'b0;
      #1;
      reset_check("midreset");
      m_cnt = 0; m_ex = '0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (DIVC + 4) step(1'b0, 32'd0, 1'b0, 1'b0, acc);

      // Undefined op 0x13 and BLTZAL
      step(1'b1, mk(6'h13, 5'd2, 6'h00), 1'b0, 1'b0, acc);
      step(1'b1, mk(6'h01, 5'h10, 6'h3F), 1'b0, 1'b0, acc);
      step(1'b0, 32'd0, 1'b0, 1'b0, acc);

      for (int i = 0; i < 200; i++) begin
         step(($urandom_range(0, 3) != 0), pick($urandom_range(0, 31)),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), acc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
